// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone arbiter for the shared RAM: host loader (m0) has priority, CPU (m1) is protected by a fairness count.
// Grant is registered, so the slave sees a request 1 cycle after arbitration; a watchdog errors out hung cycles after TIMEOUT.
module wb_ram_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int TIMEOUT    = 255,
   parameter int FAIR_LIMIT = 4
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic [AW-1:0]   m0_adr_i,
   input  logic [DW-1:0]   m0_dat_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic            m0_we_i,
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   output logic [DW-1:0]   m0_dat_o,
   output logic            m0_ack_o,
   output logic            m0_err_o,
   input  logic [AW-1:0]   m1_adr_i,
   input  logic [DW-1:0]   m1_dat_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic            m1_we_i,
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   output logic [DW-1:0]   m1_dat_o,
   output logic            m1_ack_o,
   output logic            m1_err_o,
   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic            s_we_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   input  logic [DW-1:0]   s_dat_i,
   input  logic            s_ack_i,
   input  logic            s_err_i,
   output logic [1:0]      grant_o
);

   localparam int TO_W = $clog2(TIMEOUT);
   localparam int FC_W = $clog2(FAIR_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1, ERR} state_t;

   state_t          r_state;
   logic [1:0]      r_grant;
   logic [FC_W-1:0] r_fair_cnt;
   logic [TO_W-1:0] r_to_cnt;
   logic            r_err_pulse;

   logic w_sel_m1;
   logic w_cyc;
   logic w_stb;
   logic w_in_gnt;
   logic w_resp;
   logic w_fair_full;
   logic w_fwd_ack;
   logic w_fwd_err;

   assign w_sel_m1    = r_grant[1];
   assign w_cyc       = w_sel_m1 ? m1_cyc_i : m0_cyc_i;
   assign w_stb       = w_sel_m1 ? m1_stb_i : m0_stb_i;
   assign w_in_gnt    = (r_state == GNT0) || (r_state == GNT1);
   assign w_resp      = s_ack_i | s_err_i;
   assign w_fair_full = (r_fair_cnt == FC_W'(FAIR_LIMIT));

   assign s_adr_o = w_sel_m1 ? m1_adr_i : m0_adr_i;
   assign s_dat_o = w_sel_m1 ? m1_dat_i : m0_dat_i;
   assign s_sel_o = w_sel_m1 ? m1_sel_i : m0_sel_i;
   assign s_we_o  = w_in_gnt & (w_sel_m1 ? m1_we_i : m0_we_i);
   assign s_cyc_o = w_in_gnt & w_cyc;
   assign s_stb_o = w_in_gnt & w_stb;

   // err beats ack when the slave raises both; the ERR-state pulse is only live while grant is held
   assign w_fwd_ack = w_in_gnt & s_ack_i & ~s_err_i;
   assign w_fwd_err = (w_in_gnt & s_err_i) | r_err_pulse;

   assign m0_ack_o = r_grant[0] & w_fwd_ack;
   assign m1_ack_o = r_grant[1] & w_fwd_ack;
   assign m0_err_o = r_grant[0] & w_fwd_err;
   assign m1_err_o = r_grant[1] & w_fwd_err;
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign grant_o  = r_grant;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state     <= IDLE;
         r_grant     <= 2'b00;
         r_fair_cnt  <= '0;
         r_to_cnt    <= '0;
         r_err_pulse <= 1'b0;
      end else begin
         r_err_pulse <= 1'b0;
         case (r_state)
            IDLE: begin
               r_to_cnt <= '0;
               if (!m1_cyc_i)
                  r_fair_cnt <= '0;
               if (m0_cyc_i && !(m1_cyc_i && w_fair_full)) begin
                  r_state <= GNT0;
                  r_grant <= 2'b01;
                  // reaching here with m1 waiting implies the count is below its limit
                  if (m1_cyc_i)
                     r_fair_cnt <= r_fair_cnt + FC_W'(1);
               end else if (m1_cyc_i) begin
                  r_state    <= GNT1;
                  r_grant    <= 2'b10;
                  r_fair_cnt <= '0;
               end
            end
            GNT0, GNT1: begin
               if (!w_cyc) begin
                  r_state  <= IDLE;
                  r_grant  <= 2'b00;
                  r_to_cnt <= '0;
               end else if (!w_stb || w_resp) begin
                  r_to_cnt <= '0;
               end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                  r_state     <= ERR;
                  r_err_pulse <= 1'b1;
                  r_to_cnt    <= '0;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
               end
            end
            ERR: begin
               if (!w_cyc) begin
                  r_state <= IDLE;
                  r_grant <= 2'b00;
               end
            end
            default: begin
               r_state <= IDLE;
               r_grant <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: directed arbitration/fairness/watchdog/reset scenarios followed by random two-master traffic.
// Masters push expected responses into per-master queues; a monitor pops and compares on every ack/err.
module tb_wb_ram_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TIMEOUT = 8;
   localparam int FAIR_LIMIT = 4;

   typedef struct {
      logic        err;
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] m_adr [2];
   logic [31:0] m_dat [2];
   logic [3:0]  m_sel [2];
   logic        m_we  [2];
   logic        m_cyc [2];
   logic        m_stb [2];
   logic [31:0] m_rdat[2];
   logic        m_ack [2];
   logic        m_err [2];
   logic [31:0] s_adr_o, s_dat_o, s_dat_i;
   logic [3:0]  s_sel_o;
   logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
   logic [1:0]  grant_o;

   int n_vec = 0;
   int n_miss = 0;
   int n_ack[2] = '{0, 0};
   int n_err[2] = '{0, 0};
   int sl_mode = 0;   // 0 normal, 1 never responds, 2 ack+err together
   int sl_wmin = 0;
   int sl_wmax = 0;

   exp_t        exp_q0[$];
   exp_t        exp_q1[$];
   logic [1:0]  glog[$];
   logic [31:0] ref_mem[logic [31:0]];
   logic [31:0] smem[logic [31:0]];

   wb_ram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .FAIR_LIMIT(FAIR_LIMIT)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]),
      .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_dat_o(m_rdat[0]), .m0_ack_o(m_ack[0]), .m0_err_o(m_err[0]),
      .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]),
      .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_dat_o(m_rdat[1]), .m1_ack_o(m_ack[1]), .m1_err_o(m_err[1]),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
      .grant_o(grant_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return a ^ 32'hA5A5_0F0F;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
      logic [31:0] v = old;
      for (int b = 0; b < 4; b++)
         if (sel[b]) v[8*b +: 8] = nw[8*b +: 8];
      return v;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   function automatic logic [31:0] smem_rd(input logic [31:0] a);
      return smem.exists(a) ? smem[a] : init_val(a);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // One strobe: caller holds cyc and is just past a rising edge; returns just past the edge after the response.
   task automatic m_op(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic exp_err);
      exp_t e;
      bit   got = 0;
      e.err = exp_err; e.we = we; e.adr = adr; e.sel = sel;
      if (we) begin
         e.dat = dat;
         if (!exp_err) ref_mem[adr] = merge(ref_rd(adr), dat, sel);
      end else begin
         e.dat = ref_rd(adr);
      end
      if (m == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
      m_adr[m] = adr; m_dat[m] = dat; m_sel[m] = sel; m_we[m] = we; m_stb[m] = 1'b1;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk); #1;
         if (m_ack[m] || m_err[m]) got = 1;
      end
      if (!got) begin
         n_vec++; n_miss++;
         $display("FAIL resp_timeout m%0d adr=%h: got no ack/err in 300 cycles, required one", m, adr);
      end
      @(posedge clk); #1;
      m_stb[m] = 1'b0; m_we[m] = 1'b0;
   endtask

   task automatic tenure(input int m, input int nops, input logic [31:0] base);
      m_cyc[m] = 1'b1;
      for (int k = 0; k < nops; k++)
         m_op(m, 1'($urandom_range(1, 0)), base + 32'(4 * $urandom_range(15, 0)), $urandom,
              4'($urandom_range(15, 1)), 1'b0);
      m_cyc[m] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic chk_glog(input string nm, input logic [11:0] exp_g, input int n);
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_tenure%0d", nm, i), (i < glog.size()) ? 32'(glog[i]) : 32'hFFFF_FFFF,
             32'(exp_g[2*i +: 2]));
   endtask

   task automatic check_resp(input int m);
      exp_t e;
      if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
         n_vec++; n_miss++;
         $display("FAIL unexpected_resp m%0d: got ack=%0b err=%0b, required none", m, m_ack[m], m_err[m]);
         return;
      end
      e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      chk($sformatf("m%0d_resp_grant", m), 32'(grant_o[m]), 32'd1);
      chk($sformatf("m%0d_err", m), 32'(m_err[m]), 32'(e.err));
      chk($sformatf("m%0d_ack", m), 32'(m_ack[m]), 32'(!e.err));
      if (!e.err) begin
         chk($sformatf("m%0d_s_adr", m), s_adr_o, e.adr);
         if (e.we) begin
            chk($sformatf("m%0d_s_dat", m), s_dat_o, e.dat);
            chk($sformatf("m%0d_s_sel", m), 32'(s_sel_o), 32'(e.sel));
            chk($sformatf("m%0d_s_we", m), 32'(s_we_o), 32'd1);
         end else begin
            chk($sformatf("m%0d_rdata", m), m_rdat[m], e.dat);
         end
      end
   endtask

   // Slave RAM with random wait states; responds on the falling edge so the response is held across the next rising edge.
   initial begin
      int wcnt = 0;
      int wtgt = 0;
      s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
      forever begin
         @(negedge clk);
         if (s_ack_i || s_err_i || !rst_n) begin
            s_ack_i = 1'b0; s_err_i = 1'b0; wcnt = 0;
         end else if (s_cyc_o && s_stb_o && sl_mode != 1) begin
            if (wcnt == 0) wtgt = $urandom_range(sl_wmax, sl_wmin);
            if (wcnt >= wtgt) begin
               wcnt = 0;
               s_ack_i = 1'b1;
               if (sl_mode == 2) s_err_i = 1'b1;
               else if (s_we_o) smem[s_adr_o] = merge(smem_rd(s_adr_o), s_dat_o, s_sel_o);
               else s_dat_i = smem_rd(s_adr_o);
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk); #1;
         if (rst_n) begin
            for (int m = 0; m < 2; m++) begin
               if (m_ack[m]) n_ack[m]++;
               if (m_err[m]) n_err[m]++;
               if (m_ack[m] || m_err[m]) check_resp(m);
            end
         end
      end
   end

   initial begin
      logic [1:0] prev_g = 2'b00;
      forever begin
         @(negedge clk); #1;
         if (grant_o != prev_g) begin
            if (grant_o != 2'b00) begin
               chk("idle_between_tenures", 32'(prev_g), 32'd0);
               glog.push_back(grant_o);
            end
            prev_g = grant_o;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation still running at 300000, required completion");
      $fatal(1, "bench did not finish");
   end

   initial begin
      int a0, e0, c;
      bit seen;
      rst_n = 1'b0;
      for (int m = 0; m < 2; m++) begin
         m_adr[m] = '0; m_dat[m] = '0; m_sel[m] = '0; m_we[m] = 1'b0; m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
      end
      smem[32'h200] = 32'h1234_5678;
      ref_mem[32'h200] = 32'h1234_5678;

      repeat (2) @(negedge clk); #1;
      chk("reset_outputs", 32'({grant_o, s_cyc_o, s_stb_o, s_we_o, m_ack[0], m_ack[1], m_err[0], m_err[1]}), 32'd0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;

      // single m0 write through a 1-wait-state slave
      sl_wmin = 1; sl_wmax = 1;
      a0 = n_ack[0];
      m_cyc[0] = 1'b1;
      fork
         m_op(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 1'b0);
         begin
            @(negedge clk); #1; chk("t1_grant_arb_cycle", 32'(grant_o), 32'd0);
            @(negedge clk); #1; chk("t1_grant_latency", 32'(grant_o), 32'd1);
         end
      join
      repeat (2) @(negedge clk); #1;
      chk("t1_single_ack_pulse", 32'(n_ack[0] - a0), 32'd1);
      @(posedge clk); #1; m_cyc[0] = 1'b0;
      repeat (2) @(negedge clk); #1;
      chk("t1_grant_released", 32'(grant_o), 32'd0);
      @(posedge clk); #1;

      // simultaneous request: m0 first, then m1 reads preloaded word
      sl_wmin = 0; sl_wmax = 0;
      glog.delete();
      fork
         begin m_cyc[0] = 1'b1; m_op(0, 1'b1, 32'h104, $urandom, 4'hF, 1'b0); m_cyc[0] = 1'b0; end
         begin m_cyc[1] = 1'b1; m_op(1, 1'b0, 32'h200, 32'h0, 4'hF, 1'b0); m_cyc[1] = 1'b0; end
      join
      repeat (3) begin @(posedge clk); #1; end
      chk_glog("t2", 12'b00_00_00_00_10_01, 2);

      // fairness: m0 back-to-back tenures while m1 holds cyc
      glog.delete();
      fork
         for (int k = 0; k < 5; k++) tenure(0, 1, 32'h100);
         begin
            m_cyc[1] = 1'b1;
            m_op(1, 1'b0, 32'h204, 32'h0, 4'hF, 1'b0);
            chk("t3_fair_cnt_cleared", 32'(dut.r_fair_cnt), 32'd0);
            m_cyc[1] = 1'b0;
         end
      join
      repeat (3) begin @(posedge clk); #1; end
      chk_glog("t3", 12'b01_10_01_01_01_01, 6);

      // watchdog: slave never answers
      sl_mode = 1;
      e0 = n_err[0];
      m_cyc[0] = 1'b1;
      fork
         m_op(0, 1'b1, 32'h108, 32'h5555_AAAA, 4'hF, 1'b1);
         begin
            c = 0; seen = 0;
            for (int i = 0; i < 40 && !seen; i++) begin
               @(negedge clk); #1;
               if (m_err[0]) begin
                  seen = 1;
                  chk("t4_s_cyc_in_err", 32'(s_cyc_o), 32'd0);
               end else if (s_stb_o) c++;
            end
            chk("t4_strobe_cycles", 32'(c), 32'(TIMEOUT));
         end
      join
      repeat (3) @(negedge clk); #1;
      chk("t4_grant_held", 32'(grant_o), 32'd1);
      chk("t4_single_err_pulse", 32'(n_err[0] - e0), 32'd1);
      @(posedge clk); #1; m_cyc[0] = 1'b0;
      repeat (2) @(negedge clk); #1;
      chk("t4_grant_released", 32'(grant_o), 32'd0);
      @(posedge clk); #1;

      // ack and err together: err wins
      sl_mode = 2;
      m_cyc[1] = 1'b1;
      m_op(1, 1'b0, 32'h208, 32'h0, 4'hF, 1'b1);
      m_cyc[1] = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // reset while m1 is granted with strobe up
      sl_mode = 1;
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h20C; m_we[1] = 1'b0;
      repeat (3) @(negedge clk); #1;
      chk("t6_pre_grant", 32'(grant_o), 32'd2);
      rst_n = 1'b0; #1;
      chk("t6_rst_s_cyc", 32'(s_cyc_o), 32'd0);
      chk("t6_rst_grant", 32'(grant_o), 32'd0);
      chk("t6_rst_m1_ack_err", 32'({m_ack[1], m_err[1]}), 32'd0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk); #1; chk("t6_post_rst_idle", 32'(grant_o), 32'd0);
      @(negedge clk); #1; chk("t6_post_rst_regrant", 32'(grant_o), 32'd2);
      @(posedge clk); #1; m_stb[1] = 1'b0; m_cyc[1] = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      sl_mode = 0;

      // random contention
      sl_wmin = 0; sl_wmax = 2;
      fork
         for (int k = 0; k < 20; k++) begin
            tenure(0, $urandom_range(3, 1), 32'h100);
            repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
         end
         for (int k = 0; k < 20; k++) begin
            tenure(1, $urandom_range(3, 1), 32'h200);
            repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
         end
      join
      repeat (5) @(negedge clk); #1;
      chk("m0_queue_drained", 32'(exp_q0.size()), 32'd0);
      chk("m1_queue_drained", 32'(exp_q1.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
